// File: rtl/seg_scan_display.sv
// Hex display controller: static all-digit segment bus plus a scanned single-digit bus.
// Optional per-digit blinking is compiled in with `define SEG_BLINK_EN.
module seg_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [4*NUM_DIGITS-1:0]   wr_data,
  input  logic                      lz_en,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
  output logic [7*NUM_DIGITS-1:0]   seg_all,
  output logic [6:0]                seg,
  output logic [NUM_DIGITS-1:0]     digit_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] value_reg;
  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   hide;
  logic [6:0]              dig_seg [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_all_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_reg <= '0;
    end else if (wr_en) begin
      value_reg <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == P_LAST) begin
      pre <= '0;
      idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Walk from the top digit down; a digit blanks while all higher nibbles are zero.
  always_comb begin
    logic zr;
    zr       = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zr          = zr & (value_reg[4*k +: 4] == 4'h0);
      lz_blank[k] = lz_en & zr & (k != 0);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == B_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign hide = lz_blank | (blink_mask & {NUM_DIGITS{blink_phase}});
`else
  assign hide = lz_blank;
`endif

  always_comb begin
    seg_all_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig_seg[k] = hide[k] ? 7'h7F : decode(value_reg[4*k +: 4]);
      seg_all_d[7*k +: 7] = dig_seg[k];
    end
  end

  // Both buses read the same pre-edge value_reg, so a write coinciding
  // with an idx advance is visible on the newly selected digit at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_all   <= '1;
      seg       <= 7'h7F;
      digit_sel <= '1;
    end else begin
      seg_all   <= seg_all_d;
      seg       <= dig_seg[idx];
      digit_sel <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (NUM_DIGITS=4, SCAN_DIV=3, BLINK_DIV=4).
// Expectations are queued with the cycle they are due; a negedge monitor checks them.
module tb_seg_scan_display;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        lz_en;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask;
`endif
  logic [27:0] seg_all;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;

  seg_scan_display #(
    .NUM_DIGITS(4),
    .SCAN_DIV(3),
    .BLINK_DIV(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .lz_en(lz_en),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_all(seg_all),
    .seg(seg),
    .digit_sel(digit_sel)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [27:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  logic watch5 = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int cy, input int kind,
                           input logic [27:0] v, input string n);
    exp_t e;
    e.cyc  = cy;
    e.kind = kind;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  function automatic logic [27:0] pk(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  // Monitor: compare every due expectation against the live outputs.
  always @(negedge clock) begin
    exp_t        e;
    logic [27:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = seg_all;
        1:       act = {21'b0, seg};
        default: act = {24'b0, digit_sel};
      endcase
      total++;
      if (act === e.val) passed++;
      else $display("FAIL %s @cyc %0d: got %h, want %h", e.name, e.cyc, act, e.val);
    end
    if (watch5) begin
      total++;
      if (digit_sel == 4'hB && seg == 7'h40)
        $display("FAIL no_stale @cyc %0d: got sel=%h seg=%h, want seg!=40 on sel B",
                 cyc, digit_sel, seg);
      else passed++;
    end
  end

  initial begin
    int          c;
    int          r;
    int          k;
    logic [3:0]  one;
    logic [6:0]  s12 [4];
    logic [6:0]  d1;
    exp_t        e;

    s12[0] = 7'h0E;
    s12[1] = 7'h08;
    s12[2] = 7'h24;
    s12[3] = 7'h79;

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 16'h0;
    lz_en   = 1'b0;
`ifdef SEG_BLINK_EN
    blink_mask = 4'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    tick();
    wr_en   = 1'b1;
    wr_data = 16'h12AF;
    tick();
    wr_en = 1'b0;
    repeat (7) tick();

    // Asynchronous reset between edges while displays are lit
    @(posedge clock);
    #2;
    reset = 1'b1;
    c = cyc;
    expect_at(c, 1, 28'h7F, "rst_seg");
    expect_at(c, 2, 28'hF, "rst_sel");
    expect_at(c, 0, 28'hFFFFFFF, "rst_seg_all");
    tick();
    reset = 1'b0;
    expect_at(c + 1, 1, 28'h7F, "rst_hold_seg");
    expect_at(c + 1, 2, 28'hF, "rst_hold_sel");
    expect_at(c + 1, 0, 28'hFFFFFFF, "rst_hold_seg_all");

    r = c + 2;
    expect_at(r, 0, pk(7'h40, 7'h40, 7'h40, 7'h40), "first_seg_all");
    expect_at(r, 2, 28'hE, "first_sel");
    expect_at(r, 1, 28'h40, "first_seg");
    expect_at(r + 2, 0, pk(7'h79, 7'h24, 7'h08, 7'h0E), "load_12AF");
    for (int j = 2; j <= 14; j++) begin
      k   = (j / 3) % 4;
      one = 4'b0001 << k;
      expect_at(r + j, 2, {24'b0, ~one}, "scan_sel");
      expect_at(r + j, 1, {21'b0, s12[k]}, "scan_seg");
    end
    tick();
    wr_en   = 1'b1;
    wr_data = 16'h12AF;
    tick();
    wr_en = 1'b0;

    // Leading-zero blanking
    while (cyc < r + 16) tick();
    expect_at(r + 18, 0, pk(7'h7F, 7'h7F, 7'h12, 7'h40), "lz_0050");
    expect_at(r + 19, 0, pk(7'h7F, 7'h7F, 7'h7F, 7'h40), "lz_0000");
    expect_at(r + 20, 0, pk(7'h00, 7'h40, 7'h40, 7'h40), "lz_8000");
    wr_en   = 1'b1;
    wr_data = 16'h0050;
    lz_en   = 1'b1;
    tick();
    wr_data = 16'h0000;
    tick();
    wr_data = 16'h8000;
    tick();
    wr_en = 1'b0;

    // Write coinciding with idx advance 1 -> 2
    while (cyc < r + 21) tick();
    wr_en   = 1'b1;
    wr_data = 16'h0000;
    lz_en   = 1'b0;
    tick();
    wr_en = 1'b0;
    while (cyc < r + 26) tick();
    watch5 = 1'b1;
    expect_at(r + 29, 2, 28'hD, "adv_pre_sel");
    expect_at(r + 29, 1, 28'h40, "adv_pre_seg");
    expect_at(r + 30, 2, 28'hB, "adv_sel");
    expect_at(r + 30, 1, 28'h30, "adv_seg");
    expect_at(r + 30, 0, pk(7'h30, 7'h30, 7'h30, 7'h30), "adv_seg_all");
    expect_at(r + 31, 2, 28'hB, "adv_hold_sel");
    expect_at(r + 31, 1, 28'h30, "adv_hold_seg");
    expect_at(r + 32, 2, 28'hB, "adv_hold2_sel");
    expect_at(r + 32, 1, 28'h30, "adv_hold2_seg");
    while (cyc < r + 28) tick();
    wr_en   = 1'b1;
    wr_data = 16'h3333;
    tick();
    wr_en = 1'b0;
    while (cyc < r + 33) tick();
    watch5 = 1'b0;

`ifdef SEG_BLINK_EN
    // Blink phase at edge r+j is (j/4)%2, counted from the release edge
    while (cyc < r + 34) tick();
    for (int j = 36; j <= 51; j++) begin
      d1 = ((j / 4) % 2 == 1) ? 7'h7F : 7'h30;
      expect_at(r + j, 0, pk(7'h79, 7'h24, d1, 7'h19), "blink");
    end
    wr_en      = 1'b1;
    wr_data    = 16'h1234;
    blink_mask = 4'b0010;
    tick();
    wr_en = 1'b0;
    while (cyc < r + 53) tick();
`endif

    tick();
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      $display("FAIL %s @cyc %0d: got no check, want %h", e.name, e.cyc, e.val);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
